sum_sq_iter: RTL and testbench
==============================

# sum_sq_iter

Iterative sum-of-squares stage that sits directly upstream of `sqrt_lut`. It takes one signed I/Q sample pair, computes I² + Q² with a shared shift-add datapath, and presents the 16-bit unsigned result with a one-cycle valid pulse. That pulse drives `sqrt_lut`'s `val_i`/`sqrt_lut_i` to form a magnitude path. It trades throughput for area: one serial multiplier per component, no DSP use.

## Interface
- `DW`, default 8: signed input width. Output width is 2·DW.
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `i_data`, in, DW: signed I sample, two's complement.
- `q_data`, in, DW: signed Q sample, two's complement.
- `val_i`, in, 1: input valid. A sample is accepted on an edge where `val_i && rdy_o`.
- `rdy_o`, out, 1: high only in IDLE. Decoded from the state register.
- `sum_sq_o`, out, 2·DW: I² + Q², unsigned. Holds its last value between results.
- `val_o`, out, 1: one-cycle pulse, high while in DONE.

## Operation
- **State machine:**
  - IDLE → CALC on acceptance.
  - CALC → DONE after the last bit step.
  - DONE → IDLE unconditionally.
- **Capture (acceptance edge):**
  - mi ← |i_data| and mq ← |q_data|, zero-extended to 2·DW.
  - bi ← |i_data| and bq ← |q_data|, DW-bit unsigned. |−2^(DW−1)| = 2^(DW−1) fits unsigned.
  - acc ← 0, bit counter ← 0.
- **Each CALC edge:**
  - acc ← acc + (bi[0] ? mi : 0) + (bq[0] ? mq : 0).
  - mi, mq shift left by 1. bi, bq shift right by 1. Counter increments.
- **Termination:** CALC lasts exactly DW edges; the last step is counter = DW−1.
- **Width:** the maximum result is 2·(2^(DW−1))² = 2^(2·DW−1), which fits 2·DW bits. No saturation and no overflow, so acc is 2·DW bits.
- **DONE entry:** sum_sq_o ← acc is registered on the edge that enters DONE.
- **val_i while busy:** val_i in CALC or DONE is ignored. The sample is dropped and upstream must honour `rdy_o`.
- **Reset:** `rst` high at any edge, including mid-CALC or in DONE, forces:
  - state ← IDLE;
  - acc, mi, mq, bi, bq, counter ← 0;
  - sum_sq_o ← 0, val_o ← 0.

  The in-flight sample is discarded with no val_o pulse. `val_i` is ignored on any edge where `rst` is high.
- **Output reset values:** `sum_sq_o` = 0, `val_o` = 0, `rdy_o` = 1 (IDLE).

## Timing
- Acceptance edge E0: state becomes CALC and rdy_o falls in the following cycle.
- Edges E1..E_DW perform the bit steps. E_DW enters DONE: val_o = 1 and sum_sq_o is valid in the cycle after E_DW.
- E_DW+1: IDLE and rdy_o = 1. The earliest next acceptance is E_DW+2.
- With DW = 8:
  - latency from acceptance edge to val_o-high cycle: 8 edges;
  - initiation interval: 10 cycles.
- sum_sq_o and val_o change only on the DONE-entry edge, the DONE-exit edge (val_o only) and reset.

## Configuration
- **Macro `SUM_SQ_EARLY_EXIT_EN`**
- **Defined:** at each CALC edge, if the post-shift bi and bq are both zero, the next state is DONE regardless of the counter. CALC always lasts at least 1 edge. Latency becomes 1 + max(bit-length(|i|), bit-length(|q|)) − 1 edges from acceptance to DONE, minimum 1. Results are identical.
- **Undefined:** fixed DW-edge CALC. Latency is constant, for downstream scheduling that relies on fixed cadence.

## Test plan
- **Basic result:** reset 2 cycles, then i = 3, q = 4 with val_i held high → one val_o pulse with sum_sq_o = 25. Without the macro, val_o is high in the cycle after the 8th edge following acceptance, and there is exactly one acceptance per 10 cycles.
- **Corner and boundary values:**
  - i = −128, q = −128 → 32768 (0x8000).
  - i = 127, q = −128 → 32513.
  - i = 0, q = 0 → 0.
- **Back-to-back:** val_i held high with a new pair every cycle → samples are accepted only on rdy_o edges. The result sequence matches pairs presented on those edges; others are dropped; val_o is never high on two consecutive cycles.
- **Reset mid-operation:** accept i = 100, q = 50, assert rst at E4 → no val_o. Then sum_sq_o = 0, rdy_o = 1 the cycle after reset, and the next sample (5, 12) gives 169.
- **Early exit, macro defined:**
  - i = 1, q = 0 → DONE after E1, val_o high the cycle after E1, result 1.
  - i = 0, q = 0 → same timing, result 0.
  - i = −128, q = 0 → full 8-edge CALC, result 16384.
- **Golden-vector sweep:** 1024 random pairs compared against a C reference model of i² + q², with sum_sq_o fed into `sqrt_lut`. The chained output matches the reference sqrt outputs.

Source files
------------

// File: rtl/sum_sq_iter_if.sv
// rtl/sum_sq_iter_if.sv - I/Q sample in, sum-of-squares result out, with ready/valid handshake
interface sum_sq_iter_if #(
    parameter int DW = 8
);
    logic [DW-1:0]   i_data;
    logic [DW-1:0]   q_data;
    logic            val_i;
    logic            rdy_o;
    logic [2*DW-1:0] sum_sq_o;
    logic            val_o;

    modport master (
        output i_data, q_data, val_i,
        input  rdy_o, sum_sq_o, val_o
    );

    modport slave (
        input  i_data, q_data, val_i,
        output rdy_o, sum_sq_o, val_o
    );
endinterface

// File: rtl/sum_sq_iter.sv
// rtl/sum_sq_iter.sv - serial shift-add I^2 + Q^2 stage; SUM_SQ_EARLY_EXIT_EN ends CALC once multipliers drain
module sum_sq_iter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    sum_sq_iter_if.slave  bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic [2*DW-1:0] acc, mi, mq;
    logic [2*DW-1:0] acc_next;
    logic [DW-1:0]   bi, bq;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] sum_sq;
    logic            val;
    logic            accept;

    // |x| as unsigned; the most negative value maps to 2^(DW-1), which still fits
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] x);
        return x[DW-1] ? (~x + DW'(1)) : x;
    endfunction

    assign accept   = (state == IDLE) && bus.val_i;
    assign acc_next = acc + (bi[0] ? mi : '0) + (bq[0] ? mq : '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.val_i) state_next = CALC;
            CALC: begin
`ifdef SUM_SQ_EARLY_EXIT_EN
                if (((bi >> 1) == '0) && ((bq >> 1) == '0)) state_next = DONE;
`else
                if (cnt == CW'(DW - 1)) state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mi     <= '0;
            mq     <= '0;
            bi     <= '0;
            bq     <= '0;
            cnt    <= '0;
            sum_sq <= '0;
            val    <= 1'b0;
        end else begin
            if (accept) begin
                mi  <= {{DW{1'b0}}, mag(bus.i_data)};
                mq  <= {{DW{1'b0}}, mag(bus.q_data)};
                bi  <= mag(bus.i_data);
                bq  <= mag(bus.q_data);
                acc <= '0;
                cnt <= '0;
            end else if (state == CALC) begin
                acc <= acc_next;
                mi  <= mi << 1;
                mq  <= mq << 1;
                bi  <= bi >> 1;
                bq  <= bq >> 1;
                cnt <= cnt + CW'(1);
            end
            // Result includes the final bit step, so latch the combinational sum
            if ((state == CALC) && (state_next == DONE)) begin
                sum_sq <= acc_next;
            end
            val <= (state_next == DONE);
        end
    end

    assign bus.rdy_o    = (state == IDLE);
    assign bus.sum_sq_o = sum_sq;
    assign bus.val_o    = val;
endmodule

// File: tb/tb_sum_sq_iter.sv
// tb/tb_sum_sq_iter.sv - directed vector bench for sum_sq_iter
module tb_sum_sq_iter;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sum_sq_iter_if #(.DW(DW)) bus ();

    sum_sq_iter #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] i;
        logic signed [7:0] q;
        int                exp;
        int                lat_early;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pair(input string name, input logic [7:0] i, input logic [7:0] q,
                            input int exp, input int lat);
        int n;
        bit seen;
        chk({name, " rdy_before"}, int'(bus.rdy_o), 1);
        bus.i_data = i;
        bus.q_data = q;
        bus.val_i  = 1'b1;
        tick();
        bus.val_i = 1'b0;
        chk({name, " rdy_busy"}, int'(bus.rdy_o), 0);
        seen = 1'b0;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.val_o) begin
                seen = 1'b1;
                n = k;
                break;
            end
        end
        chk({name, " val_seen"}, int'(seen), 1);
        chk({name, " latency"}, n, lat);
        chk({name, " sum"}, int'(bus.sum_sq_o), exp);
        tick();
        chk({name, " val_drop"}, int'(bus.val_o), 0);
        chk({name, " sum_hold"}, int'(bus.sum_sq_o), exp);
    endtask

    initial begin
        int   expq[$];
        int   acc_cyc[$];
        int   prev_val;
        int   iv, qv, lat;
        logic [7:0] pi, pq;

        vecs[0] = '{8'sd3,    8'sd4,    25,    3};
        vecs[1] = '{-8'sd128, -8'sd128, 32768, 8};
        vecs[2] = '{8'sd127,  -8'sd128, 32513, 8};
        vecs[3] = '{8'sd0,    8'sd0,    0,     1};
        vecs[4] = '{8'sd1,    8'sd0,    1,     1};
        vecs[5] = '{-8'sd128, 8'sd0,    16384, 8};
        vecs[6] = '{8'sd5,    8'sd12,   169,   4};
        vecs[7] = '{-8'sd1,   -8'sd1,   2,     1};
        vecs[8] = '{-8'sd100, 8'sd50,   12500, 7};
        vecs[9] = '{-8'sd7,   8'sd0,    49,    3};

        bus.i_data = '0;
        bus.q_data = '0;
        bus.val_i  = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.val_i = 1'b0;
        chk("reset rdy", int'(bus.rdy_o), 1);
        chk("reset val", int'(bus.val_o), 0);
        chk("reset sum", int'(bus.sum_sq_o), 0);

        foreach (vecs[v]) begin
`ifdef SUM_SQ_EARLY_EXIT_EN
            lat = vecs[v].lat_early;
`else
            lat = 8;
`endif
            run_pair($sformatf("vec%0d", v), vecs[v].i, vecs[v].q, vecs[v].exp, lat);
        end

        // Reset in the middle of CALC: no pulse, result cleared
        run_pair("pre_rst", 8'sd3, 8'sd4, 25, vecs[0].lat_early == 0 ? 0 :
`ifdef SUM_SQ_EARLY_EXIT_EN
                 3);
`else
                 8);
`endif
        bus.i_data = 8'sd100;
        bus.q_data = 8'sd50;
        bus.val_i  = 1'b1;
        tick();
        bus.val_i = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus.val_i = 1'b1;
        tick();
        rst = 1'b0;
        bus.val_i = 1'b0;
        chk("midrst val", int'(bus.val_o), 0);
        chk("midrst sum", int'(bus.sum_sq_o), 0);
        chk("midrst rdy", int'(bus.rdy_o), 1);
        prev_val = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            prev_val |= int'(bus.val_o);
        end
        chk("midrst no_pulse", prev_val, 0);
        run_pair("post_rst", 8'sd5, 8'sd12, 169,
`ifdef SUM_SQ_EARLY_EXIT_EN
                 4);
`else
                 8);
`endif

        // Back-to-back: new pair every cycle, only rdy_o edges accept
        prev_val = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.val_o) begin
                if (prev_val != 0) chk("b2b consecutive_val", 1, 0);
                if (expq.size() == 0) chk("b2b unexpected_val", 1, 0);
                else chk($sformatf("b2b result c%0d", c), int'(bus.sum_sq_o), expq.pop_front());
            end
            prev_val = int'(bus.val_o);
            if (c < 45) begin
                pi = 8'(c * 37 + 5);
                pq = 8'(c * 91 - 3);
                if (bus.rdy_o) begin
                    iv = int'($signed(pi));
                    qv = int'($signed(pq));
                    expq.push_back(iv * iv + qv * qv);
                    acc_cyc.push_back(c);
                end
                bus.i_data = pi;
                bus.q_data = pq;
                bus.val_i  = 1'b1;
            end else begin
                bus.val_i = 1'b0;
            end
            tick();
        end
        chk("b2b drained", expq.size(), 0);
        chk("b2b accepts", int'(acc_cyc.size() >= 4), 1);
`ifndef SUM_SQ_EARLY_EXIT_EN
        for (int a = 1; a < acc_cyc.size(); a++) begin
            chk($sformatf("b2b interval%0d", a), acc_cyc[a] - acc_cyc[a-1], 10);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
